// File: rtl/adc_cap_pkg.sv
// adc_cap_pkg: shared encodings and defaults for the triggered ADC capture buffer
package adc_cap_pkg;
   localparam int DEF_NCH = 2;
   localparam int DEF_DW  = 8;
   typedef enum logic [1:0] {
      TRIG_IMM = 2'd0,
      TRIG_THR = 2'd1,
      TRIG_EXT = 2'd2,
      TRIG_RSV = 2'd3
   } trig_mode_e;
   typedef enum logic [2:0] {
      S_IDLE,
      S_PRE,
      S_ARMED,
      S_POST,
      S_DONE
   } cap_state_e;
endpackage

// File: rtl/cap_ram.sv
// cap_ram: simple dual-port RAM with synchronous read, maps onto block RAM
module cap_ram #(
   parameter int AW = 10,
   parameter int W  = 16
) (
   input  logic          clk_i,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [W-1:0]  wdata_i,
   input  logic          re_i,
   input  logic [AW-1:0] raddr_i,
   output logic [W-1:0]  rdata_o
);
   logic [W-1:0] mem_q [2**AW];
   // write port
   always_ff @(posedge clk_i)
      if (we_i) mem_q[waddr_i] <= wdata_i;
   // registered read port, no reset so it packs into block RAM
   always_ff @(posedge clk_i)
      if (re_i) rdata_o <= mem_q[raddr_i];
endmodule

// File: rtl/adc_trig_capture.sv
// adc_trig_capture: pre-trigger circular capture with ordered replay and ramp checker
module adc_trig_capture
   import adc_cap_pkg::*;
#(
   parameter int NCH = DEF_NCH,
   parameter int DW  = DEF_DW,
   parameter int AW  = 10,
   parameter int EW  = 16,
   parameter int TW  = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic              dclk,
   input  logic              mr,
   input  logic [NCH*DW-1:0] din,
   input  logic              din_valid,
   input  logic              arm,
   input  logic [1:0]        trig_mode,
   input  logic [TW-1:0]     trig_ch,
   input  logic [DW-1:0]     threshold,
   input  logic              ext_trig,
   input  logic [AW-1:0]     pretrig,
   input  logic              rd_en,
   output logic [NCH*DW-1:0] rd_data,
   output logic              rd_valid,
   output logic              rd_last,
   output logic              busy,
   output logic              done,
   input  logic              pat_en,
   output logic [NCH-1:0]    pat_err,
   output logic [EW-1:0]     err_cnt
);
   localparam int DEPTH = 2**AW;
   localparam int W     = NCH*DW;

   cap_state_e    state_q, state_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW-1:0] trig_addr_q, trig_addr_d, pretrig_q, pretrig_d, pre_cnt_q, pre_cnt_d;
   logic [AW:0]   post_cnt_q, post_cnt_d, rd_cnt_q, rd_cnt_d, post_tgt;
   logic [DW-1:0] prev_q, prev_d, cur;
   logic          ext_prev_q, ext_pend_q, ext_pend_d, ext_edge, fire;
   logic          rd_valid_q, rd_last_q, we, re;
   logic [W-1:0]  ram_rdata;

   logic          pat_en_q, seeded_q, seeded_d;
   logic [W-1:0]  exp_q, exp_d;
   logic [NCH-1:0] pat_err_q, pat_err_d, mism;
   logic [EW-1:0] err_cnt_q, err_cnt_d;
   logic [EW:0]   sum;
   int            nmis;

   assign busy     = state_q inside {S_PRE, S_ARMED, S_POST};
   assign done     = state_q == S_DONE;
   assign rd_valid = rd_valid_q;
   assign rd_last  = rd_last_q;
   assign rd_data  = rd_valid_q ? ram_rdata : '0;
   assign pat_err  = pat_err_q;
   assign err_cnt  = err_cnt_q;
   assign cur      = din[trig_ch*DW +: DW];
   assign ext_edge = ext_trig && !ext_prev_q;
   assign post_tgt = (AW+1)'(DEPTH) - {1'b0, pretrig_q};

   // capture FSM next state, write/read strobes and pointer updates
   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      trig_addr_d = trig_addr_q;
      pretrig_d   = pretrig_q;
      pre_cnt_d   = pre_cnt_q;
      post_cnt_d  = post_cnt_q;
      rd_cnt_d    = rd_cnt_q;
      prev_d      = (din_valid && busy) ? cur : prev_q;
      ext_pend_d  = ext_pend_q || (state_q == S_ARMED && ext_edge);
      we          = 1'b0;
      re          = 1'b0;
      fire        = din_valid && ((trig_mode == TRIG_IMM) ||
                                  (trig_mode == TRIG_THR && prev_q < threshold && cur >= threshold) ||
                                  (trig_mode == TRIG_EXT && (ext_pend_q || ext_edge)));
      case (state_q)
         S_PRE: begin
            we        = din_valid;
            pre_cnt_d = pre_cnt_q + AW'(din_valid);
            if (pre_cnt_q == pretrig_q || pre_cnt_d == pretrig_q) state_d = S_ARMED;
         end
         S_ARMED: begin
            we = din_valid;
            if (fire) begin
               trig_addr_d = wr_ptr_q;
               post_cnt_d  = (AW+1)'(1);
               ext_pend_d  = 1'b0;
               state_d     = (post_tgt == (AW+1)'(1)) ? S_DONE : S_POST;
            end
         end
         S_POST: begin
            we         = din_valid;
            post_cnt_d = post_cnt_q + (AW+1)'(din_valid);
            if (post_cnt_d == post_tgt) state_d = S_DONE;
         end
         S_DONE: begin
            re = rd_en && !rd_cnt_q[AW];
            if (re) rd_ptr_d = rd_ptr_q + AW'(1);
            if (re) rd_cnt_d = rd_cnt_q + (AW+1)'(1);
            if (rd_last_q) state_d = S_IDLE;
         end
         default: ;
      endcase
      if (we) wr_ptr_d = wr_ptr_q + AW'(1);
      if (arm && (state_q == S_IDLE || state_q == S_DONE)) begin
         state_d    = S_PRE;
         wr_ptr_d   = '0;
         pre_cnt_d  = '0;
         pretrig_d  = pretrig;
         prev_d     = '1;
         ext_pend_d = 1'b0;
         re         = 1'b0;
      end
      if (state_d == S_DONE && state_q != S_DONE) begin
         rd_ptr_d = trig_addr_d - pretrig_q;
         rd_cnt_d = '0;
      end
   end

   // capture state registers
   always_ff @(posedge dclk or negedge mr)
      if (!mr) begin
         state_q     <= S_IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         trig_addr_q <= '0;
         pretrig_q   <= '0;
         pre_cnt_q   <= '0;
         post_cnt_q  <= '0;
         rd_cnt_q    <= '0;
         prev_q      <= '1;
         ext_prev_q  <= 1'b0;
         ext_pend_q  <= 1'b0;
         rd_valid_q  <= 1'b0;
         rd_last_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         trig_addr_q <= trig_addr_d;
         pretrig_q   <= pretrig_d;
         pre_cnt_q   <= pre_cnt_d;
         post_cnt_q  <= post_cnt_d;
         rd_cnt_q    <= rd_cnt_d;
         prev_q      <= prev_d;
         ext_prev_q  <= ext_trig;
         ext_pend_q  <= ext_pend_d;
         rd_valid_q  <= re;
         rd_last_q   <= re && rd_cnt_q == (AW+1)'(DEPTH-1);
      end

   cap_ram #(.AW(AW), .W(W)) u_ram (
      .clk_i   (dclk),
      .we_i    (we),
      .waddr_i (wr_ptr_q),
      .wdata_i (din),
      .re_i    (re),
      .raddr_i (rd_ptr_q),
      .rdata_o (ram_rdata)
   );

   // ramp checker: seed after pat_en rises, then expect +1 per channel and resync on every sample
   always_comb begin
      seeded_d  = seeded_q && !(pat_en && !pat_en_q);
      pat_err_d = (pat_en && !pat_en_q) ? '0 : pat_err_q;
      err_cnt_d = (pat_en && !pat_en_q) ? '0 : err_cnt_q;
      exp_d     = exp_q;
      mism      = '0;
      nmis      = 0;
      for (int k = 0; k < NCH; k++) begin
         mism[k] = din[k*DW +: DW] != exp_q[k*DW +: DW];
         nmis    = nmis + int'(mism[k]);
      end
      sum = {1'b0, err_cnt_d} + (EW+1)'(nmis);
      if (pat_en && din_valid) begin
         for (int k = 0; k < NCH; k++) exp_d[k*DW +: DW] = din[k*DW +: DW] + DW'(1);
         if (seeded_d) pat_err_d = pat_err_d | mism;
         if (seeded_d) err_cnt_d = sum[EW] ? '1 : sum[EW-1:0];
         seeded_d = 1'b1;
      end
   end

   // ramp checker registers
   always_ff @(posedge dclk or negedge mr)
      if (!mr) begin
         pat_en_q  <= 1'b0;
         seeded_q  <= 1'b0;
         exp_q     <= '0;
         pat_err_q <= '0;
         err_cnt_q <= '0;
      end else begin
         pat_en_q  <= pat_en;
         seeded_q  <= seeded_d;
         exp_q     <= exp_d;
         pat_err_q <= pat_err_d;
         err_cnt_q <= err_cnt_d;
      end
endmodule

// File: tb/tb_adc_trig_capture.sv
// tb_adc_trig_capture: directed checks of capture, triggers, replay, ramp checker and reset
module tb_adc_trig_capture;
   logic        dclk = 1'b0, mr = 1'b0;
   logic [15:0] din = '0;
   logic        din_valid = 1'b0, arm = 1'b0, ext_trig = 1'b0, rd_en = 1'b0, pat_en = 1'b0;
   logic [1:0]  trig_mode = '0;
   logic [0:0]  trig_ch = '0;
   logic [7:0]  threshold = '0;
   logic [3:0]  pretrig = '0;
   logic [15:0] rd_data;
   logic        rd_valid, rd_last, busy, done;
   logic [1:0]  pat_err;
   logic [3:0]  err_cnt;
   int          n = 0, errs = 0;

   adc_trig_capture #(.NCH(2), .DW(8), .AW(4), .EW(4)) dut (
      .dclk(dclk), .mr(mr), .din(din), .din_valid(din_valid), .arm(arm),
      .trig_mode(trig_mode), .trig_ch(trig_ch), .threshold(threshold), .ext_trig(ext_trig),
      .pretrig(pretrig), .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
      .rd_last(rd_last), .busy(busy), .done(done), .pat_en(pat_en), .pat_err(pat_err),
      .err_cnt(err_cnt)
   );

   always #5 dclk = ~dclk;

   function automatic logic [15:0] w(input logic [7:0] v);
      return {8'(v + 8'h80), v};
   endfunction

   task automatic tick;
      @(posedge dclk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [15:0] d);
      din = d;
      din_valid = 1'b1;
      tick;
      din_valid = 1'b0;
   endtask

   task automatic do_arm(input logic [1:0] mode, input logic [3:0] pre);
      trig_mode = mode;
      pretrig = pre;
      arm = 1'b1;
      tick;
      arm = 1'b0;
   endtask

   task automatic replay(input string tag, input logic [7:0] first, input bit gaps);
      for (int i = 0; i < 16; i++) begin
         rd_en = 1'b1;
         tick;
         rd_en = 1'b0;
         chk($sformatf("%s_valid%0d", tag, i), rd_valid, 1'b1);
         chk($sformatf("%s_data%0d", tag, i), rd_data, w(8'(first + i)));
         chk($sformatf("%s_last%0d", tag, i), rd_last, i == 15);
         if (gaps || i == 15) begin
            tick;
            chk($sformatf("%s_gap%0d", tag, i), rd_valid, 1'b0);
         end
      end
      chk({tag, "_done_clr"}, done, 1'b0);
   endtask

   initial begin
      tick;
      tick;
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_rd_valid", rd_valid, 1'b0);
      chk("rst_rd_last", rd_last, 1'b0);
      chk("rst_rd_data", rd_data, 16'h0);
      chk("rst_pat_err", pat_err, 2'b00);
      chk("rst_err_cnt", err_cnt, 4'h0);
      mr = 1'b1;
      tick;

      do_arm(2'd0, 4'd0);
      chk("imm_busy", busy, 1'b1);
      tick;
      for (int i = 0; i < 15; i++) push(w(8'(i)));
      chk("imm_not_done", done, 1'b0);
      push(w(8'd15));
      chk("imm_done", done, 1'b1);
      chk("imm_idle", busy, 1'b0);
      replay("imm", 8'd0, 1'b0);
      rd_en = 1'b1;
      tick;
      rd_en = 1'b0;
      chk("rd_outside_done", rd_valid, 1'b0);

      trig_ch = 1'b1;
      threshold = 8'h80;
      do_arm(2'd1, 4'd4);
      for (int i = 0; i < 28; i++) push(w(8'(8'hF0 + i)));
      chk("thr_done", done, 1'b1);
      replay("thr", 8'hFC, 1'b0);

      do_arm(2'd1, 4'd0);
      tick;
      for (int i = 0; i < 20; i++) push({8'h90, 8'(i)});
      chk("thr_high_no_fire", done, 1'b0);
      chk("thr_high_busy", busy, 1'b1);
      push({8'h10, 8'd20});
      for (int i = 21; i < 37; i++) push({8'h90, 8'(i)});
      chk("thr_refire_done", done, 1'b1);
      rd_en = 1'b1;
      tick;
      rd_en = 1'b0;
      chk("thr_refire_word", rd_data, {8'h90, 8'd21});

      do_arm(2'd2, 4'd3);
      chk("rearm_done_clr", done, 1'b0);
      chk("rearm_busy", busy, 1'b1);
      for (int i = 0; i < 40; i++) push(w(8'(i)));
      chk("ext_wait", busy, 1'b1);
      ext_trig = 1'b1;
      for (int i = 40; i < 53; i++) push(w(8'(i)));
      ext_trig = 1'b0;
      chk("ext_done", done, 1'b1);
      replay("ext", 8'd37, 1'b0);

      do_arm(2'd0, 4'd5);
      for (int i = 0; i < 16; i++) begin
         tick;
         arm = (i == 8);
         push(w(8'(i)));
         arm = 1'b0;
         if (i == 14) chk("gap_busy", busy, 1'b1);
      end
      chk("gap_done", done, 1'b1);
      replay("gap", 8'd0, 1'b1);

      pat_en = 1'b1;
      push(w(8'h20));
      push(w(8'h21));
      push(w(8'h22));
      chk("pat_clean", err_cnt, 4'd0);
      push({8'hA3, 8'h55});
      chk("pat_err1", pat_err, 2'b01);
      chk("pat_cnt1", err_cnt, 4'd1);
      push(w(8'h24));
      chk("pat_cnt2", err_cnt, 4'd2);
      for (int i = 8'h25; i < 8'h29; i++) push(w(8'(i)));
      chk("pat_stable_cnt", err_cnt, 4'd2);
      chk("pat_stable_err", pat_err, 2'b01);
      pat_en = 1'b0;
      tick;
      pat_en = 1'b1;
      tick;
      chk("pat_clr_cnt", err_cnt, 4'd0);
      chk("pat_clr_err", pat_err, 2'b00);
      for (int i = 0; i < 8; i++) push(w(8'h00));
      chk("pat_cnt14", err_cnt, 4'd14);
      push(w(8'h00));
      push(w(8'h00));
      chk("pat_sat", err_cnt, 4'd15);
      chk("pat_both", pat_err, 2'b11);
      pat_en = 1'b0;

      do_arm(2'd0, 4'd0);
      tick;
      for (int i = 0; i < 5; i++) push(w(8'(8'h30 + i)));
      chk("post_busy", busy, 1'b1);
      #2 mr = 1'b0;
      #1;
      chk("arst_busy", busy, 1'b0);
      chk("arst_done", done, 1'b0);
      chk("arst_rd_valid", rd_valid, 1'b0);
      chk("arst_err_cnt", err_cnt, 4'd0);
      chk("arst_pat_err", pat_err, 2'b00);
      tick;
      mr = 1'b1;
      tick;
      do_arm(2'd0, 4'd0);
      tick;
      for (int i = 0; i < 16; i++) push(w(8'(8'h60 + i)));
      chk("arst_recap_done", done, 1'b1);
      replay("arst", 8'h60, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n, errs);
      $finish;
   end
endmodule

// File: doc/adc_trig_capture.md
Name: adc_trig_capture

Overview:
- Parametrised, triggered, pre-trigger-capable capture buffer for the AD9284 sample path on ML605.
- Sits after the LVDS deserialiser in the dclk domain and replaces the plain capture FIFO.
- Holds NCH channels of DW-bit samples in a circular RAM and freezes a window around a trigger event.
- Replays the frozen window in chronological order; a concurrent ramp-pattern checker supports ADC link bring-up.

Parameters:
- NCH, 2, number of ADC channels packed in din.
- DW, 8, sample width per channel.
- AW, 10, RAM address width; DEPTH = 2^AW words of NCH*DW bits.
- EW, 16, width of the pattern error counter.

Ports:
- dclk  in  1  sample clock; all logic is single-clock.
- mr  in  1  master reset, asynchronous, active-low.
- din  in  NCH*DW  channel samples; channel k occupies bits [k*DW +: DW].
- din_valid  in  1  din qualifier.
- arm  in  1  single-cycle request to start a capture.
- trig_mode  in  2  0 = immediate, 1 = threshold rising, 2 = external rising edge, 3 = reserved (never triggers).
- trig_ch  in  clog2(NCH)  channel used for threshold triggering.
- threshold  in  DW  unsigned trigger level.
- ext_trig  in  1  external trigger, already synchronous to dclk.
- pretrig  in  AW  number of samples kept before the trigger.
- rd_en  in  1  pops one word during replay.
- rd_data  out  NCH*DW  replayed word.
- rd_valid  out  1  rd_data qualifier.
- rd_last  out  1  marks the final replayed word.
- busy  out  1  high in PRE, ARMED and POST.
- done  out  1  capture frozen and ready for replay.
- pat_en  in  1  enables the ramp checker.
- pat_err  out  NCH  sticky per-channel mismatch flags.
- err_cnt  out  EW  saturating total mismatch count.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; pointers and counters 0.
- FSM states: IDLE, PRE, ARMED, POST, DONE.
- Sampling: pretrig is sampled on arm and clamped to DEPTH-1.
- Writes: one RAM write per din_valid cycle in PRE, ARMED and POST at wr_ptr; wr_ptr then increments mod DEPTH.
- IDLE/DONE -> PRE on arm: wr_ptr=0, pre_cnt=0, done=0.
- arm while busy is ignored.
- PRE: after pretrig valid writes -> ARMED. pretrig=0 -> ARMED on the cycle after arm.
- ARMED: writes continue and wrap freely. The trigger is evaluated only on din_valid samples:
  - mode 0: the first valid sample.
  - mode 1: prev < threshold and cur >= threshold on trig_ch. prev is the last valid sample of that channel and is reset to all-ones on arm, so a level already high does not fire.
  - mode 2: ext_trig 0->1 edge registered per cycle; it fires with the next valid sample.
  - The trigger sample is written; trig_addr = its address -> POST with post_cnt=1.
- POST: continues writing until post_cnt = DEPTH - pretrig (trigger sample included) -> DONE.
- Frozen window: start_addr = trig_addr - pretrig mod DEPTH.
- DONE: done=1; rd_ptr = start_addr.
  - Each rd_en reads RAM[rd_ptr] and increments rd_ptr.
  - rd_valid and rd_data appear exactly 1 cycle after rd_en.
  - The DEPTH-th word has rd_last=1; the next cycle the FSM returns to IDLE and done=0.
  - rd_en outside DONE is ignored (rd_valid stays 0).
  - arm during DONE discards the remaining replay and restarts PRE.
- Simultaneous write and read are impossible by construction (disjoint states); the RAM is simple dual-port with synchronous read.
- Pattern checker runs independently of the FSM, on valid samples while pat_en=1.
  - The first valid sample after a pat_en rise seeds the expected value per channel.
  - Afterwards expected = previous + 1 mod 2^DW.
  - A mismatch sets pat_err[k] and adds the number of mismatching channels in that sample to err_cnt, saturating at 2^EW-1.
  - The checker resyncs its expected value to the received sample.
  - pat_err and err_cnt clear only on the pat_en rising edge or on reset.
- Reset mid-operation: everything returns to reset values immediately; a partial capture is lost.

Decomposition:
- Shared package adc_cap_pkg holds:
  - The trig_mode encodings TRIG_IMM, TRIG_THR, TRIG_EXT.
  - The FSM state encodings.
  - Default DW/NCH constants.
- One sub-module, cap_ram: parametrised simple dual-port synchronous-read RAM of DEPTH x NCH*DW that infers block RAM.
- The pattern checker stays inline.

Test Plan:
- Immediate trigger: NCH=2, DW=8, AW=4, pretrig=0, ramp input, arm -> done after 16 valid samples; replay returns 16 consecutive ramp words, rd_last on the 16th, then done=0.
- Threshold trigger, pretrig=4, threshold=0x80, ramp on ch1 from 0x70 -> first replayed ch1 sample 0x7C, the 5th is 0x80, rd_last on 0x8B.
- Wrap in ARMED: pretrig=3, mode 2, ext_trig rises after 40 valid samples (values 0..39, ext_trig sampled with value 40) -> replay 37,38,39,40,...,52.
- Gaps and arm while busy: din_valid toggling 50% with a second arm pulse during POST -> the capture window is unaffected, 16 words replayed, rd_valid 1 cycle after each rd_en.
- Pattern checker: pat_en=1, ramp with ch0 sample 0x23 replaced by 0x55 -> pat_err=2'b01, err_cnt=1; subsequent 0x24.. gives err_cnt=2 (resync at 0x55 expects 0x56), then stable.
- Async reset: assert mr low mid-POST -> busy, done, rd_valid, err_cnt read 0 in the same cycle; after release, arm works normally.
